// File: rtl/bcd_digit_streamer.sv
// -----------------------------------------------------------------------------
// bcd_digit_streamer
//
// Multi-digit synchronous BCD up/down counter with a digit-serial snapshot
// port. On request, the current count is latched and sent one BCD digit per
// transfer over a valid/ready port, most-significant digit first. The digit
// bus uses the same bit ordering as the downstream BCD-to-Gray converter:
// bit 0 is the MSB (the 8s bit).
//
// Vector ordering: count/load_val are [0:4*DIGITS-1]. Digit d occupies bits
// [4*d : 4*d+3], and digit 0 is the MSD.
//
// Handshake: the digit port is a plain valid/ready port. A digit is
// transferred on each rising edge where dig_valid and dig_ready are both high.
// While dig_valid is high and dig_ready is low, dig_data, dig_idx and
// dig_last hold. dig_valid never drops without a transfer, except on reset.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   en         count enable
//   up         1 = count up, 0 = count down
//   load       load load_val into count; each digit above 9 saturates to 9
//   load_val   parallel load value
//   count      registered BCD count
//   wrap       registered one-cycle pulse when count wraps around
//   tc         combinational terminal count
//   snap       request a digit-serial snapshot; ignored while busy
//   busy       snapshot stream in progress
//   dig_valid  dig_data is valid
//   dig_ready  downstream accepts the digit
//   dig_data   presented BCD digit
//   dig_idx    index of the presented digit, 0 = MSD
//   dig_last   presented digit is the LSD
//   dbg_state  streamer FSM state (0 = IDLE, 1 = SEND)
// -----------------------------------------------------------------------------
module bcd_digit_streamer #(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [0:4*DIGITS-1]   load_val,
  output logic [0:4*DIGITS-1]   count,
  output logic                  wrap,
  output logic                  tc,
  input  logic                  snap,
  output logic                  busy,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [0:3]            dig_data,
  output logic [0:2]            dig_idx,
  output logic                  dig_last,
  output logic                  dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  logic [0:4*DIGITS-1] r_count;
  logic                r_wrap;
  logic [0:4*DIGITS-1] r_snap;
  logic [2:0]          r_idx;
  logic                r_busy;
  logic                r_valid;
  logic [0:3]          r_data;
  logic                r_last;
  state_t              r_state;

  logic [0:4*DIGITS-1] w_count_nxt;
  logic [0:4*DIGITS-1] w_load_sat;
  logic [3:0]          w_dig;
  logic [3:0]          w_ld_dig;
  logic                w_carry;
  logic                w_all9;
  logic                w_all0;
  logic                w_xfer;

  // Select digit idx of a snapshot vector.
  function automatic logic [3:0] digit_of(input logic [0:4*DIGITS-1] v,
                                          input logic [2:0] idx);
    digit_of = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == 3'(d)) digit_of = v[4*d +: 4];
    end
  endfunction

  // Next-count logic. The carry/borrow starts at the LSD and ripples toward
  // the MSD. It keeps propagating only through 9s (up) or 0s (down).
  always_comb begin
    w_count_nxt = r_count;
    w_load_sat  = load_val;
    w_dig       = 4'd0;
    w_ld_dig    = 4'd0;
    w_carry     = 1'b1;
    w_all9      = 1'b1;
    w_all0      = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      w_dig = r_count[4*d +: 4];
      if (w_dig != 4'd9) w_all9 = 1'b0;
      if (w_dig != 4'd0) w_all0 = 1'b0;
      if (w_carry) begin
        if (up) begin
          w_count_nxt[4*d +: 4] = (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
          w_carry               = (w_dig == 4'd9);
        end else begin
          w_count_nxt[4*d +: 4] = (w_dig == 4'd0) ? 4'd9 : w_dig - 4'd1;
          w_carry               = (w_dig == 4'd0);
        end
      end
      w_ld_dig = load_val[4*d +: 4];
      if (w_ld_dig > 4'd9) w_load_sat[4*d +: 4] = 4'd9;
    end
  end

  // tc also marks the cycle whose count step wraps around.
  assign tc     = en & ((up & w_all9) | (~up & w_all0));
  assign w_xfer = r_valid & dig_ready;

  // Counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_sat;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_count <= w_count_nxt;
      r_wrap  <= tc;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  // Streamer FSM. The outputs are registered, so each one is set up on the
  // edge that enters or advances SEND.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_idx   <= 3'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 4'd0;
      r_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (snap) begin
            // r_count here is the value before this edge's counter update.
            r_state <= S_SEND;
            r_snap  <= r_count;
            r_idx   <= 3'd0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_data  <= r_count[0:3];
            r_last  <= (DIGITS == 1);
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_idx   <= 3'd0;
              r_busy  <= 1'b0;
              r_valid <= 1'b0;
              r_data  <= 4'd0;
              r_last  <= 1'b0;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_data  <= digit_of(r_snap, r_idx + 3'd1);
              r_last  <= ((r_idx + 3'd1) == 3'(DIGITS - 1));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign count     = r_count;
  assign wrap      = r_wrap;
  assign busy      = r_busy;
  assign dig_valid = r_valid;
  assign dig_data  = r_data;
  assign dig_idx   = r_idx;
  assign dig_last  = r_last;
  assign dbg_state = (r_state == S_SEND);

endmodule

// File: tb/tb_bcd_digit_streamer.sv
module tb_bcd_digit_streamer;

  localparam int DIGITS = 2;
  localparam int MAXV   = 100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset;
  logic                en;
  logic                up;
  logic                load;
  logic [0:4*DIGITS-1] load_val;
  logic [0:4*DIGITS-1] count;
  logic                wrap;
  logic                tc;
  logic                snap;
  logic                busy;
  logic                dig_valid;
  logic                dig_ready;
  logic [0:3]          dig_data;
  logic [0:2]          dig_idx;
  logic                dig_last;
  logic                dbg_state;

  bcd_digit_streamer #(.DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count), .wrap(wrap), .tc(tc),
    .snap(snap), .busy(busy), .dig_valid(dig_valid), .dig_ready(dig_ready),
    .dig_data(dig_data), .dig_idx(dig_idx), .dig_last(dig_last),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  logic [3:0] exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  m_count  = 0;
  bit  m_wrap   = 0;
  bit  m_busy   = 0;
  int  m_idx    = 0;
  int  xfer_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] to_bcd(input int v);
    logic [63:0] r;
    int t;
    int digs[DIGITS];
    t = v;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      digs[d] = t % 10;
      t = t / 10;
    end
    r = '0;
    for (int d = 0; d < DIGITS; d++) r = (r << 4) | 64'(digs[d]);
    return r;
  endfunction

  function automatic int sat_load(input logic [0:4*DIGITS-1] lv);
    int v;
    int dg;
    v = 0;
    for (int d = 0; d < DIGITS; d++) begin
      dg = int'(lv[4*d +: 4]);
      if (dg > 9) dg = 9;
      v = v * 10 + dg;
    end
    return v;
  endfunction

  task automatic push_frame(input int v);
    int t;
    int digs[DIGITS];
    t = v;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      digs[d] = t % 10;
      t = t / 10;
    end
    for (int d = 0; d < DIGITS; d++) exp_q.push_back(4'(digs[d]));
  endtask

  // ---------------- one clock step: model update + checks ----------------
  task automatic step();
    bit xfer;
    logic [3:0] exp_d;
    xfer = m_busy && (dig_ready === 1'b1);
    if (xfer) begin
      if (exp_q.size() == 0) begin
        check("xfer_queue_empty", 64'd1, 64'd0);
      end else begin
        exp_d = exp_q.pop_front();
        check("xfer_data", 64'(dig_data), 64'(exp_d));
        check("xfer_idx", 64'(dig_idx), 64'(m_idx));
        check("xfer_last", 64'(dig_last), 64'(m_idx == DIGITS - 1));
        xfer_cnt++;
      end
    end
    @(posedge clk);
    if (reset) begin
      m_count = 0; m_wrap = 0; m_busy = 0; m_idx = 0;
      exp_q.delete();
    end else begin
      if (!m_busy) begin
        if (snap) begin
          push_frame(m_count);
          m_busy = 1;
          m_idx  = 0;
        end
      end else if (xfer) begin
        if (m_idx == DIGITS - 1) begin
          m_busy = 0;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end
      if (load) begin
        m_count = sat_load(load_val);
        m_wrap  = 0;
      end else if (en) begin
        if (up) begin
          m_wrap  = (m_count == MAXV - 1);
          m_count = m_wrap ? 0 : m_count + 1;
        end else begin
          m_wrap  = (m_count == 0);
          m_count = m_wrap ? MAXV - 1 : m_count - 1;
        end
      end else begin
        m_wrap = 0;
      end
    end
    #1;
    check("count", 64'(count), to_bcd(m_count));
    check("wrap", 64'(wrap), 64'(m_wrap));
    check("tc", 64'(tc),
          64'(en & ((up & (m_count == MAXV - 1)) | (!up & (m_count == 0)))));
    check("busy", 64'(busy), 64'(m_busy));
    check("dig_valid", 64'(dig_valid), 64'(m_busy));
    check("dig_idx", 64'(dig_idx), 64'(m_idx));
    if (m_busy) begin
      check("dig_last", 64'(dig_last), 64'(m_idx == DIGITS - 1));
      if (exp_q.size() != 0) check("dig_data_hold", 64'(dig_data), 64'(exp_q[0]));
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    reset = 1; en = 0; up = 1; load = 0; load_val = '0; snap = 0; dig_ready = 0;

    // Reset state
    step(); step();
    check("rst_dig_data", 64'(dig_data), 64'd0);
    check("rst_dig_last", 64'(dig_last), 64'd0);
    en = 1; up = 0; #1;
    check("rst_tc_down", 64'(tc), 64'd1);
    up = 1; #1;
    check("rst_tc_up", 64'(tc), 64'd0);

    // Up-count through full wrap
    reset = 0; en = 1; up = 1;
    for (int i = 0; i < 100; i++) step();
    check("up_wrapped_to_00", 64'(count), 64'h00);

    // Down-count with borrow
    en = 0; load = 1; load_val = 8'h10; step();
    load = 0; en = 1; up = 0; step();
    check("down_10_to_09", 64'(count), 64'h09);
    for (int i = 0; i < 10; i++) step();
    check("down_wrap_99", 64'(count), 64'h99);

    // Load saturation and priority
    load = 1; en = 1; load_val = 8'hC3; step();
    check("load_sat_93", 64'(count), 64'h93);
    check("load_no_wrap", 64'(wrap), 64'd0);
    load_val = 8'hFF; step();
    check("load_sat_99", 64'(count), 64'h99);
    reset = 1; step();
    check("reset_over_load", 64'(count), 64'h00);
    reset = 0; load = 0; en = 0;

    // Stream with backpressure, counter running during the stream
    load = 1; load_val = 8'h47; step();
    load = 0; dig_ready = 0; snap = 1; step();
    snap = 0; en = 1; up = 1;
    check("snap_latency_valid", 64'(dig_valid), 64'd1);
    check("snap_msd", 64'(dig_data), 64'd4);
    for (int i = 0; i < 3; i++) step();
    dig_ready = 1;
    xfer_cnt = 0;
    for (int i = 0; i < 10 && m_busy; i++) step();
    check("bp_frame_done", 64'(busy), 64'd0);
    check("bp_frame_xfers", 64'(xfer_cnt), 64'(DIGITS));

    // snap held through the whole frame, including the last-transfer cycle
    en = 0; load = 1; load_val = 8'h58; step();
    load = 0; dig_ready = 1; snap = 1; xfer_cnt = 0;
    for (int i = 0; i < DIGITS + 1; i++) step();
    snap = 0; step();
    check("snap_busy_ignored", 64'(busy), 64'd0);
    check("snap_busy_xfers", 64'(xfer_cnt), 64'(DIGITS));
    snap = 1; step();
    snap = 0;
    check("new_frame_start", 64'(busy), 64'd1);
    for (int i = 0; i < 10 && m_busy; i++) step();
    check("new_frame_done", 64'(busy), 64'd0);

    // Reset mid-stream after the first transfer
    en = 1; up = 0; snap = 1; step();
    snap = 0; step();
    reset = 1; step();
    reset = 0;
    check("midrst_valid", 64'(dig_valid), 64'd0);
    check("midrst_idx", 64'(dig_idx), 64'd0);
    check("midrst_count", 64'(count), 64'h00);
    check("midrst_data", 64'(dig_data), 64'd0);

    // Random mix
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      en        = 1'($urandom_range(0, 1));
      up        = 1'($urandom_range(0, 1));
      load      = ($urandom_range(0, 9) == 0);
      load_val  = 8'($urandom_range(0, 255));
      snap      = ($urandom_range(0, 3) == 0);
      dig_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_digit_streamer.md
# bcd_digit_streamer

Multi-digit synchronous BCD up/down counter with a digit-serial output port. It sits directly upstream of the BCD-to-Gray converter stage. On request it snapshots the count and presents one 4-bit BCD digit per transfer, most-significant digit first, using a valid/ready handshake. The digit bus uses the converter's bit ordering, so it can drive the converter directly.

## Interface
- DIGITS, 2: number of BCD digits, legal range 1..8
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable
- up  input  1  1 = count up, 0 = count down
- load  input  1  load load_val into count
- load_val  input  [0:4*DIGITS-1]  parallel load value; digit 0 = bits [0:3] = MSD
- count  output  [0:4*DIGITS-1]  registered BCD count; same digit order
- wrap  output  1  registered one-cycle pulse on wrap-around
- tc  output  1  combinational terminal count
- snap  input  1  request a digit-serial snapshot
- busy  output  1  snapshot in progress
- dig_valid  output  1  dig_data is valid
- dig_ready  input  1  downstream accepts the digit
- dig_data  output  [0:3]  BCD digit; bit 0 = MSB (8s)
- dig_idx  output  [0:2]  index of the presented digit, 0 = MSD
- dig_last  output  1  presented digit is the LSD

## Operation
- **Counter priority:** reset > load > en. With none of these asserted, count holds.
- **Load:** each loaded digit greater than 9 is forced to 9. Valid digits load unchanged. wrap stays 0 on load.
- **Count up:** the LSD increments. Carry ripples across digits on 9→0. The all-9s value becomes all-0s and wrap=1.
- **Count down:** the LSD decrements. Borrow ripples across digits on 0→9. The all-0s value becomes all-9s and wrap=1.
- **tc:** tc = en & ((up & count==all-9s) | (!up & count==all-0s)).
- **Digit range:** every digit of count is always in 0..9.
- **Streamer FSM:** states IDLE and SEND.
- **IDLE:** busy=0, dig_valid=0. If snap=1, latch count as it is before this edge's counter update, set idx=0, and go to SEND.
- **SEND:** busy=1, dig_valid=1, dig_data = snapshot digit idx, dig_last = (idx==DIGITS-1).
  - A transfer occurs when dig_valid & dig_ready.
  - On a transfer with dig_last=0: idx increments and the FSM stays in SEND.
  - On a transfer with dig_last=1: go to IDLE and clear idx to 0.
- **Stable data:** while dig_valid=1 and dig_ready=0, dig_data, dig_idx and dig_last hold.
- **snap while busy:** ignored. This includes the cycle of the last transfer. No queuing.
- **Independence:** the counter runs independently of the streamer. Counting, loading or wrapping during SEND does not alter the snapshot.
- **Reset mid-operation:** reset aborts any stream and clears all state in the same edge.

## Timing
- **Reset values:** count=0, wrap=0, busy=0, dig_valid=0, dig_data=0, dig_idx=0, dig_last=0. tc follows its equation (tc = en & !up after reset).
- **Count latency:** count updates one edge after the en/load sample. wrap is asserted in the same cycle that count first shows the wrapped value, for exactly one cycle.
- **Snapshot latency:** 1 cycle. snap sampled high at edge N gives dig_valid=1 with the MSD in the cycle after edge N.
- **Throughput:** one digit per cycle. With dig_ready held high, a frame takes exactly DIGITS cycles.
- **Back-to-back frames:** the earliest next snap is sampled at the edge after the last transfer. A new frame therefore starts with at least one idle cycle.
- **DIGITS=1:** dig_last=1 throughout SEND.
- **Handshake:** dig_ready may be asserted before dig_valid. Only the cycle in which both are high counts as a transfer.

## Test plan
- **Reset and up-count:** reset, then up=1, en=1 for 100 cycles with DIGITS=2 → count steps 00,01,…,09,10,…,99,00. wrap=1 only in the cycle count=00 after 99. tc=1 only while count=99.
- **Down-count with borrow:** load 4'h1,4'h0 (10), then up=0, en=1 → count 09 after one edge. Continuing down, 00 goes to 99 with wrap=1.
- **Load saturation and priority:** load=1, en=1, load_val=4'hC,4'h3 → count=93 and wrap=0. Assert reset together with load → count=00.
- **Stream with backpressure:** count=47, snap=1 for one cycle, dig_ready low for 3 cycles then high → dig_data=4 with dig_idx=0 held for 4 cycles, then dig_data=7 with dig_idx=1 and dig_last=1. busy drops after that transfer. Counting during the stream does not change the 4,7 values.
- **snap while busy:** snap asserted during SEND and on the last-transfer cycle → ignored; exactly DIGITS transfers per frame. A snap after returning to IDLE starts a new frame one cycle later.
- **Reset mid-stream:** reset after the first transfer → next cycle dig_valid=0, busy=0, dig_idx=0, count=00.
